// File: rtl/adat_tx_frame_encoder.sv
// ADAT transmit frame builder and NRZI line encoder: one 8x24-bit sample set per 256-bit frame.
// Optional edge monitor outputs (o_edge, o_edge_time) are compiled in with ADAT_TX_EDGE_MON_EN.
module adat_tx_frame_encoder #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_enable,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [191:0] i_data,
   input  logic [3:0]   i_user,
   output logic         o_adat,
   output logic         o_frame_start,
   output logic         o_underrun,
   output logic         o_busy
`ifdef ADAT_TX_EDGE_MON_EN
   ,
   output logic         o_edge,
   output logic [11:0]  o_edge_time
`endif
);

   localparam logic [7:0] DIV_MAX = 8'(CLKS_PER_BIT - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t       state, state_n;
   logic [7:0]   div, div_n;
   logic [7:0]   bit_idx, bit_n;
   logic [2:0]   grp, grp_n;
   logic [195:0] sr, sr_n;
   logic [195:0] hold_frame, frame_in;
   logic         hold_full, hold_full_n;
   logic         enter, start_n, bit_val, shift, accept, transfer;

   // Holding register stores the set already in line order: user[3:0], then ch0..ch7, MSB first.
   always_comb begin
      frame_in = '0;
      frame_in[195:192] = i_user;
      for (int unsigned k = 0; k < 8; k++)
         frame_in[191 - 24*k -: 24] = i_data[24*k +: 24];
   end

   always_comb begin
      state_n = state;
      div_n   = div;
      bit_n   = bit_idx;
      enter   = 1'b0;
      start_n = 1'b0;
      case (state)
         IDLE: begin
            if (i_enable) begin
               state_n = RUN;
               div_n   = '0;
               bit_n   = '0;
               enter   = 1'b1;
               start_n = 1'b1;
            end
         end
         RUN: begin
            if (div == DIV_MAX) begin
               div_n = '0;
               enter = 1'b1;
               if (bit_idx == 8'd255) begin
                  bit_n = '0;
                  if (i_enable)
                     start_n = 1'b1;
                  else
                     state_n = IDLE;
               end else begin
                  bit_n = bit_idx + 8'd1;
               end
            end else begin
               div_n = div + 8'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Value of the bit cell being entered; grp tracks position inside each 4+1 data group.
   always_comb begin
      bit_val = 1'b0;
      shift   = 1'b0;
      grp_n   = grp;
      if (enter && state_n == RUN) begin
         if (bit_n == 8'd10) begin
            bit_val = 1'b1;
         end else if (bit_n >= 8'd11 && bit_n <= 8'd14) begin
            bit_val = sr[195];
            shift   = 1'b1;
         end else if (bit_n == 8'd15) begin
            bit_val = 1'b1;
            grp_n   = '0;
         end else if (bit_n >= 8'd16) begin
            if (grp == 3'd4) begin
               bit_val = 1'b1;
               grp_n   = '0;
            end else begin
               bit_val = sr[195];
               shift   = 1'b1;
               grp_n   = grp + 3'd1;
            end
         end
      end
   end

   assign accept   = i_valid & o_ready;
   assign transfer = o_frame_start;

   always_comb begin
      hold_full_n = hold_full;
      if (accept)
         hold_full_n = 1'b1;
      else if (transfer)
         hold_full_n = 1'b0;

      sr_n = sr;
      if (transfer)
         sr_n = hold_full ? hold_frame : '0;
      else if (shift)
         sr_n = {sr[194:0], 1'b0};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state         <= IDLE;
         div           <= '0;
         bit_idx       <= '0;
         grp           <= '0;
         sr            <= '0;
         hold_frame    <= '0;
         hold_full     <= 1'b0;
         o_ready       <= 1'b1;
         o_adat        <= 1'b0;
         o_frame_start <= 1'b0;
         o_underrun    <= 1'b0;
      end else begin
         state         <= state_n;
         div           <= div_n;
         bit_idx       <= bit_n;
         grp           <= grp_n;
         sr            <= sr_n;
         if (accept)
            hold_frame <= frame_in;
         hold_full     <= hold_full_n;
         o_ready       <= ~hold_full_n;
         o_adat        <= o_adat ^ bit_val;
         o_frame_start <= start_n;
         // A set accepted in the frame-start cycle still counts as pending for the next frame.
         o_underrun    <= start_n & ~hold_full_n;
      end
   end

   assign o_busy = (state == RUN);

`ifdef ADAT_TX_EDGE_MON_EN
   logic [11:0] edge_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         edge_cnt    <= '0;
         o_edge      <= 1'b0;
         o_edge_time <= '0;
      end else begin
         o_edge <= bit_val;
         if (bit_val) begin
            o_edge_time <= (edge_cnt == 12'hFFF) ? 12'hFFF : edge_cnt + 12'd1;
            edge_cnt    <= '0;
         end else if (edge_cnt != 12'hFFF) begin
            edge_cnt <= edge_cnt + 12'd1;
         end
      end
   end
`endif

endmodule
